// File: rtl/acc_x_responder_pkg.sv
// acc_x_responder shared types: op and FSM enums, funct3 codes, decoder.
// Optional macro ACC_X_RSP_ILLEGAL_EN: report illegal ops instead of ADD.
package acc_x_responder_pkg;

   typedef enum logic [2:0] {
      OP_ADD,
      OP_ADD3,
      OP_MUL,
      OP_MAC,
      OP_MULHU,
      OP_ILLEGAL
   } acc_x_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } acc_x_rsp_state_e;

   localparam logic [2:0] F3_ADD   = 3'b000;
   localparam logic [2:0] F3_ADD3  = 3'b001;
   localparam logic [2:0] F3_MUL   = 3'b010;
   localparam logic [2:0] F3_MAC   = 3'b011;
   localparam logic [2:0] F3_MULHU = 3'b100;

   function automatic acc_x_op_e acc_x_decode(
      input logic [2:0] f3,
      input logic       has_rs3
   );
      acc_x_op_e op;
      op = OP_ILLEGAL;
      unique case (1'b1)
         (f3 == F3_ADD):   op = OP_ADD;
         (f3 == F3_ADD3):  op = OP_ADD3;
         (f3 == F3_MUL):   op = OP_MUL;
         (f3 == F3_MAC):   op = OP_MAC;
         (f3 == F3_MULHU): op = OP_MULHU;
         default:          op = OP_ILLEGAL;
      endcase
      // 3-operand ops need a third source port
      if (!has_rs3 && (op == OP_ADD3 || op == OP_MAC))
         op = OP_ILLEGAL;
`ifndef ACC_X_RSP_ILLEGAL_EN
      if (op == OP_ILLEGAL)
         op = OP_ADD;
`endif
      return op;
   endfunction

endpackage

// File: rtl/acc_x_responder_if.sv
// Offload X request/response bundle between core side and responder.
// master: core side drives q_* and p_ready; slave: responder.
interface acc_x_responder_if #(
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned NumRs       = 3,
   parameter int unsigned HartIdWidth = 1
);
   logic [31:0]                       q_instr_data;
   logic [NumRs-1:0][DataWidth-1:0]   q_rs;
   logic [4:0]                        q_rd;
   logic [HartIdWidth-1:0]            q_hart_id;
   logic                              q_valid;
   logic                              q_ready;
   logic [DataWidth-1:0]              p_data;
   logic [4:0]                        p_rd;
   logic [HartIdWidth-1:0]            p_hart_id;
   logic                              p_we;
   logic                              p_error;
   logic                              p_valid;
   logic                              p_ready;

   modport master (
      output q_instr_data, q_rs, q_rd,
      output q_hart_id, q_valid, p_ready,
      input  q_ready, p_data, p_rd,
      input  p_hart_id, p_we, p_error, p_valid
   );

   modport slave (
      input  q_instr_data, q_rs, q_rd,
      input  q_hart_id, q_valid, p_ready,
      output q_ready, p_data, p_rd,
      output p_hart_id, p_we, p_error, p_valid
   );
endinterface

// File: rtl/acc_x_responder_serial_mul.sv
// acc_serial_mul: unsigned shift-add multiplier, fixed DataWidth cycles.
// Ports: start_i loads a_i/b_i; done_o pulses on last cycle with product_o.
module acc_serial_mul #(
   parameter int unsigned DataWidth = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [DataWidth-1:0]     a_i,
   input  logic [DataWidth-1:0]     b_i,
   output logic                     done_o,
   output logic [2*DataWidth-1:0]   product_o
);
   localparam int unsigned CntW = $clog2(DataWidth);
   localparam logic [CntW-1:0] Last = CntW'(DataWidth - 1);

   logic                   run_q;
   logic [CntW-1:0]        cnt_q;
   logic [2*DataWidth-1:0] mcand_q;
   logic [DataWidth-1:0]   mplier_q;
   logic [2*DataWidth-1:0] acc_q;
   logic [2*DataWidth-1:0] sum;

   // product_o is the accumulator after this cycle's bit, so the
   // final value is available in the same cycle done_o is high
   assign sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done_o    = run_q && (cnt_q == Last);
   assign product_o = sum;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start_i) begin
         run_q    <= 1'b1;
         cnt_q    <= '0;
         mcand_q  <= {{DataWidth{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
      end else if (run_q) begin
         acc_q    <= sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (cnt_q == Last)
            run_q <= 1'b0;
      end
   end
endmodule

// File: rtl/acc_x_responder.sv
// Offload X responder: ADD/ADD3 in one cycle, MUL/MAC/MULHU serially.
// Ports: clk_i, rst_i (sync high), bus (slave), busy_o. ACC_X_RSP_ILLEGAL_EN.
module acc_x_responder
   import acc_x_responder_pkg::*;
#(
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned NumRs       = 3,
   parameter int unsigned HartIdWidth = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   acc_x_responder_if.slave   bus,
   output logic               busy_o
);
   acc_x_rsp_state_e state_q, state_d;
   acc_x_op_e        op_in, op_q;

   logic                   hs, mul_in, mul_done;
   logic                   alu_err;
   logic [2*DataWidth-1:0] prod;
   logic [DataWidth-1:0]   rs1, rs2, rs3;
   logic [DataWidth-1:0]   alu_res, mul_res, rs3_q;
   logic [4:0]             rd_q;
   logic [HartIdWidth-1:0] hart_q;
   logic [DataWidth-1:0]   data_q;
   logic [4:0]             p_rd_q;
   logic [HartIdWidth-1:0] p_hart_q;
   logic                   we_q;

   assign rs1 = bus.q_rs[0];
   assign rs2 = bus.q_rs[1];

   if (NumRs > 2) begin : g_rs3
      assign rs3 = bus.q_rs[2];
   end else begin : g_no_rs3
      assign rs3 = '0;
   end

   assign op_in  = acc_x_decode(bus.q_instr_data[14:12], NumRs > 2);
   assign mul_in = op_in inside {OP_MUL, OP_MAC, OP_MULHU};

   // a waiting response retiring frees the slot in the same cycle
   assign bus.q_ready = (state_q == IDLE) ||
                        (state_q == RESP && bus.p_ready);
   assign hs          = bus.q_valid && bus.q_ready;

   assign bus.p_valid   = (state_q == RESP);
   assign bus.p_data    = data_q;
   assign bus.p_rd      = p_rd_q;
   assign bus.p_hart_id = p_hart_q;
   assign bus.p_we      = we_q;
   assign busy_o        = (state_q != IDLE);

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      unique case (op_in)
         OP_ADD:     alu_res = rs1 + rs2;
         OP_ADD3:    alu_res = rs1 + rs2 + rs3;
         OP_ILLEGAL: alu_err = 1'b1;
         default:    alu_res = '0;
      endcase
   end

   always_comb begin
      mul_res = prod[DataWidth-1:0];
      unique case (op_q)
         OP_MAC:   mul_res = prod[DataWidth-1:0] + rs3_q;
         OP_MULHU: mul_res = prod[2*DataWidth-1:DataWidth];
         default:  mul_res = prod[DataWidth-1:0];
      endcase
   end

   acc_serial_mul #(
      .DataWidth (DataWidth)
   ) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (hs && mul_in),
      .a_i       (rs1),
      .b_i       (rs2),
      .done_o    (mul_done),
      .product_o (prod)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (hs)
               state_d = mul_in ? EXEC : RESP;
            else if (state_q == RESP && bus.p_ready)
               state_d = IDLE;
         end
         EXEC: begin
            if (mul_done)
               state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q   <= '0;
         p_rd_q   <= '0;
         p_hart_q <= '0;
         we_q     <= 1'b0;
         op_q     <= OP_ADD;
         rs3_q    <= '0;
         rd_q     <= '0;
         hart_q   <= '0;
      end else begin
         if (hs && !mul_in) begin
            data_q   <= alu_res;
            p_rd_q   <= bus.q_rd;
            p_hart_q <= bus.q_hart_id;
            we_q     <= !alu_err;
         end
         if (hs && mul_in) begin
            op_q   <= op_in;
            rs3_q  <= rs3;
            rd_q   <= bus.q_rd;
            hart_q <= bus.q_hart_id;
         end
         if (mul_done) begin
            data_q   <= mul_res;
            p_rd_q   <= rd_q;
            p_hart_q <= hart_q;
            we_q     <= 1'b1;
         end
      end
   end

`ifdef ACC_X_RSP_ILLEGAL_EN
   logic err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         err_q <= 1'b0;
      else if (hs && !mul_in)
         err_q <= alu_err;
      else if (mul_done)
         err_q <= 1'b0;
   end

   assign bus.p_error = err_q;
`else
   assign bus.p_error = 1'b0;
`endif
endmodule

// File: tb/tb_acc_x_responder.sv
// Directed bench for acc_x_responder.
// Expectations for funct3=111 follow ACC_X_RSP_ILLEGAL_EN.
module tb_acc_x_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   acc_x_responder_if bus ();

   acc_x_responder dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0]  f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] c,
                        input logic [4:0]  rd,
                        input logic        h);
      bus.q_instr_data = {17'h0, f3, 5'd0, 7'h0B};
      bus.q_rs         = {c, b, a};
      bus.q_rd         = rd;
      bus.q_hart_id    = h;
      bus.q_valid      = 1'b1;
      @(posedge clk);
      #1;
      bus.q_valid = 1'b0;
      bus.q_rs    = '1;
      bus.q_rd    = 5'd31;
      bus.q_hart_id = ~h;
   endtask

   // counts cycles from the one after handshake until p_valid
   task automatic wait_rsp(output int lat, output int qr_bad);
      lat    = 1;
      qr_bad = 0;
      @(negedge clk);
      while (!bus.p_valid && lat < 100) begin
         if (bus.q_ready) qr_bad++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_mul(input string tag,
                          input logic [2:0]  f3,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] c,
                          input logic [31:0] exp);
      int lat, qb;
      issue(f3, a, b, c, 5'd9, 1'b0);
      wait_rsp(lat, qb);
      chk({tag, "_lat"}, 64'(lat), 64'd33);
      chk({tag, "_data"}, 64'(bus.p_data), 64'(exp));
      chk({tag, "_qready_exec"}, 64'(qb), 64'd0);
      chk({tag, "_we"}, 64'(bus.p_we), 64'd1);
      chk({tag, "_rd"}, 64'(bus.p_rd), 64'd9);
   endtask

   initial begin
      int lat, qb, bad;
      logic [31:0] exp_b2b [4];

      bus.q_instr_data = '0;
      bus.q_rs         = '0;
      bus.q_rd         = '0;
      bus.q_hart_id    = '0;
      bus.q_valid      = 1'b0;
      bus.p_ready      = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_q_ready", 64'(bus.q_ready), 64'd1);
      chk("rst_p_valid", 64'(bus.p_valid), 64'd0);
      chk("rst_p_data", 64'(bus.p_data), 64'd0);
      chk("rst_p_rd", 64'(bus.p_rd), 64'd0);
      chk("rst_p_hart", 64'(bus.p_hart_id), 64'd0);
      chk("rst_p_we", 64'(bus.p_we), 64'd0);
      chk("rst_p_err", 64'(bus.p_error), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single-cycle ADD
      issue(3'b000, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1);
      wait_rsp(lat, qb);
      chk("add_lat", 64'(lat), 64'd1);
      chk("add_data", 64'(bus.p_data), 64'd12);
      chk("add_rd", 64'(bus.p_rd), 64'd3);
      chk("add_hart", 64'(bus.p_hart_id), 64'd1);
      chk("add_we", 64'(bus.p_we), 64'd1);
      chk("add_err", 64'(bus.p_error), 64'd0);
      bus.p_ready = 1'b1;
      @(negedge clk);
      chk("add_retired", 64'(bus.p_valid), 64'd0);

      // ADD3 with wrap
      issue(3'b001, 32'hFFFF_FFFF, 32'd2, 32'd3, 5'd4, 1'b0);
      wait_rsp(lat, qb);
      chk("add3_lat", 64'(lat), 64'd1);
      chk("add3_data", 64'(bus.p_data), 64'd4);

      // serial multiplier ops
      run_mul("mac", 3'b011, 32'h1_0000, 32'h1_0000, 32'd3, 32'd3);
      run_mul("mulhu", 3'b100, 32'h1_0000, 32'h1_0000, 32'd0, 32'd1);
      run_mul("mul_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'd0, 32'h0000_0001);
      run_mul("mulhu_ff", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'd0, 32'hFFFF_FFFE);
      run_mul("mul_zero", 3'b010, 32'h1234, 32'd0, 32'd0, 32'd0);
      run_mul("mul_small", 3'b010, 32'd6, 32'd7, 32'd0, 32'd42);

      // back-to-back ADDs, then a stalled response
      @(negedge clk);
      bus.p_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_b2b[i] = 32'(i * 16 + 1) + 32'(i + 2);
         bus.q_instr_data = 32'h0000_000B;
         bus.q_rs  = {32'd0, 32'(i + 2), 32'(i * 16 + 1)};
         bus.q_rd  = 5'(i);
         bus.q_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("b2b_valid", 64'(bus.p_valid), 64'd1);
         chk("b2b_data", 64'(bus.p_data), 64'(exp_b2b[i]));
      end
      bus.p_ready = 1'b0;
      bus.q_rs    = {32'd0, 32'd200, 32'd100};
      bus.q_rd    = 5'd7;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.p_valid !== 1'b1 || bus.p_data !== exp_b2b[3] ||
             bus.p_rd !== 5'd3 || bus.q_ready !== 1'b0)
            bad++;
      end
      chk("stall_stable", 64'(bad), 64'd0);
      bus.p_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.q_valid = 1'b0;
      @(negedge clk);
      chk("stall_next_valid", 64'(bus.p_valid), 64'd1);
      chk("stall_next_data", 64'(bus.p_data), 64'd300);
      chk("stall_next_rd", 64'(bus.p_rd), 64'd7);
      @(negedge clk);

      // funct3 = 111
      issue(3'b111, 32'd5, 32'd6, 32'd0, 5'd2, 1'b1);
      wait_rsp(lat, qb);
      chk("ill_lat", 64'(lat), 64'd1);
`ifdef ACC_X_RSP_ILLEGAL_EN
      chk("ill_err", 64'(bus.p_error), 64'd1);
      chk("ill_we", 64'(bus.p_we), 64'd0);
      chk("ill_data", 64'(bus.p_data), 64'd0);
`else
      chk("ill_err", 64'(bus.p_error), 64'd0);
      chk("ill_we", 64'(bus.p_we), 64'd1);
      chk("ill_data", 64'(bus.p_data), 64'd11);
`endif
      @(negedge clk);

      // reset during a multiply
      issue(3'b010, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd5, 1'b1);
      repeat (9) @(posedge clk);
      #1;
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_p_valid", 64'(bus.p_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_q_ready", 64'(bus.q_ready), 64'd1);
      chk("abort_p_data", 64'(bus.p_data), 64'd0);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.p_valid !== 1'b0) bad++;
      end
      chk("abort_no_stale", 64'(bad), 64'd0);
      issue(3'b000, 32'd2, 32'd3, 32'd0, 5'd6, 1'b0);
      wait_rsp(lat, qb);
      chk("post_rst_lat", 64'(lat), 64'd1);
      chk("post_rst_data", 64'(bus.p_data), 64'd5);
      chk("post_rst_rd", 64'(bus.p_rd), 64'd6);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/acc_x_responder.md
Name: acc_x_responder

Overview:
- Accelerator-side endpoint of the offload X interface. Accepts offloaded instructions with their source operands from the core-side interconnect, executes a small integer op set, and returns a writeback response tagged with rd and hart ID.
- Single-cycle ops are handled combinationally. Multiplies use an iterative shift-add unit.
- Serves as the reference responder that hangs off one leaf of the accelerator interconnect.

Parameters:
- DataWidth, 32, operand/result width (ISA width).
- NumRs, 3, number of source operand ports (2 or 3).
- HartIdWidth, 1, hart-ID tag width, echoed unchanged.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- q_instr_data_i  in  32  offloaded instruction word
- q_rs_i  in  NumRs x DataWidth  source operands rs1..rsN
- q_rd_i  in  5  destination register
- q_hart_id_i  in  HartIdWidth  requester tag
- q_valid_i  in  1  request valid
- q_ready_o  out  1  request ready
- p_data_o  out  DataWidth  writeback data
- p_rd_o  out  5  echoed rd
- p_hart_id_o  out  HartIdWidth  echoed tag
- p_we_o  out  1  writeback enable
- p_error_o  out  1  illegal instruction
- p_valid_o  out  1  response valid
- p_ready_i  in  1  response ready
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous, active-high (rst_i).
- Reset values: state=IDLE; q_ready_o=1; p_valid_o=0; p_data_o=0; p_rd_o=0; p_hart_id_o=0; p_we_o=0; p_error_o=0; busy_o=0.
- Decode uses funct3 = instr[14:12]:
  - 000 ADD: rs1+rs2.
  - 001 ADD3: rs1+rs2+rs3. Illegal if NumRs=2.
  - 010 MUL: low half of rs1*rs2 (unsigned).
  - 011 MAC: low(rs1*rs2)+rs3. Illegal if NumRs=2.
  - 100 MULHU: high half of rs1*rs2.
  - 101..111: illegal.
- Arithmetic: all adds wrap modulo 2^DataWidth. The product is 2*DataWidth bits.
- Request handshake occurs when q_valid_i && q_ready_o. q_ready_o = (state==IDLE) || (state==RESP && p_ready_i).
- FSM:
  - IDLE/RESP, on handshake of a single-cycle or illegal op: compute and register the result, go to RESP.
  - IDLE/RESP, on handshake of a mul-class op: latch operands, clear the accumulator and counter, go to EXEC.
  - EXEC: one multiplier bit per cycle, counter 0..DataWidth-1. After the last bit, register the result and go to RESP.
  - RESP with p_ready_i and no new handshake: go to IDLE.
- Latency (handshake at cycle N):
  - Single-cycle or illegal op: p_valid_o from N+1.
  - Mul-class op: EXEC occupies N+1..N+DataWidth; p_valid_o from N+DataWidth+1.
- Back-to-back: in RESP, if p_ready_i and q_valid_i are high in the same cycle, the response retires and the new request is accepted in that cycle. Single-cycle ops therefore sustain 1 op/cycle.
- Stability: while p_valid_o && !p_ready_i, all p_* outputs hold stable.
- Operands and tags are captured at handshake. Input changes after handshake are ignored.
- Echo: p_rd_o and p_hart_id_o carry the captured q_rd_i and q_hart_id_i.
- Errors (with feature enabled): illegal op gives p_error_o=1, p_we_o=0, p_data_o=0. Legal op gives p_we_o=1, p_error_o=0.
- Reset mid-operation (any state): abort the op, drop any pending response, return to reset values the next cycle. No response is produced for the aborted op.
- Operand edge cases: rs2=0 still takes the full DataWidth cycles (fixed latency). 0xFFFFFFFF*0xFFFFFFFF gives MUL=0x00000001 and MULHU=0xFFFFFFFE.

Optional Feature:
- Macro: ACC_X_RSP_ILLEGAL_EN.
- Defined: illegal funct3 (or a 3-operand op with NumRs=2) responds per the error rule above, after 1 cycle.
- Undefined: illegal encodings execute as ADD. p_error_o is tied 0 and p_we_o is always 1.

Decomposition:
- acc_pkg additions:
  - Enum acc_x_op_e {OP_ADD, OP_ADD3, OP_MUL, OP_MAC, OP_MULHU, OP_ILLEGAL}.
  - Funct3 localparams.
  - FSM enum acc_x_rsp_state_e {IDLE, EXEC, RESP}.
- Sub-module acc_serial_mul: start/done handshake and a 2*DataWidth shift-add accumulator. Fixed DataWidth-cycle latency, done pulses on the final cycle.

Test Plan:
- ADD: rs1=5, rs2=7, rd=3, hart=1 -> one cycle later p_valid=1, p_data=12, p_rd=3, p_hart_id=1, p_we=1.
- MAC: rs1=0x10000, rs2=0x10000, rs3=3 -> p_valid exactly 33 cycles after handshake, p_data=3. MULHU with the same rs1/rs2 -> 0x1.
- MUL and MULHU of 0xFFFFFFFF by 0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE. q_ready=0 throughout EXEC.
- Back-to-back: 4 ADDs with p_ready=1 -> 4 responses on consecutive cycles. Then p_ready=0 for 5 cycles -> outputs stable, q_ready=0.
- funct3=111 with macro defined -> p_error=1, p_we=0, p_data=0. Without macro -> ADD result, p_error=0.
- rst_i asserted at cycle 10 of a MUL -> next cycle state IDLE, p_valid=0. No stale response after reset release; a new ADD completes normally.
